// File: rtl/shift_feeder.sv
// Serializes parallel words into single-bit frames for a 4-stage shift register,
// with one holding entry so consecutive frames stream out with no idle gap.
//
// state | meaning
// IDLE  | no frame active; serial outputs low, Mode keeps last direction
// SHIFT | active entry driving bit bit_cnt of its frame
module shift_feeder #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             in_valid,
    input  logic             in_dir,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             Mode,
    output logic             ShiftRight,
    output logic             ShiftLeft,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hold_data;
    logic             hold_dir;
    logic             hold_valid;
    logic [WIDTH-1:0] act_data, act_data_nxt;
    logic             act_dir, act_dir_nxt;
    logic [1:0]       bit_cnt, bit_cnt_nxt;

    logic accept, load, last_bit;
    logic mode_nxt, sr_nxt, sl_nxt, busy_nxt, done_nxt;

    assign in_ready = !hold_valid;
    assign accept   = in_valid && !hold_valid;
    assign last_bit = (state == SHIFT) && (bit_cnt == 2'd3);
    assign load     = hold_valid && ((state == IDLE) || last_bit);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            hold_data  <= '0;
            hold_dir   <= 1'b0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_data  <= in_data;
            hold_dir   <= in_dir;
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state      <= IDLE;
            act_data   <= '0;
            act_dir    <= 1'b0;
            bit_cnt    <= 2'd0;
            Mode       <= 1'b0;
            ShiftRight <= 1'b0;
            ShiftLeft  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            act_data   <= act_data_nxt;
            act_dir    <= act_dir_nxt;
            bit_cnt    <= bit_cnt_nxt;
            Mode       <= mode_nxt;
            ShiftRight <= sr_nxt;
            ShiftLeft  <= sl_nxt;
            busy       <= busy_nxt;
            frame_done <= done_nxt;
        end
    end

    // Outputs are registered from the next-state values so the bit driven in a
    // cycle always matches the active entry's counter for that cycle.
    always_comb begin
        state_nxt    = state;
        act_data_nxt = act_data;
        act_dir_nxt  = act_dir;
        bit_cnt_nxt  = bit_cnt;

        if (load) begin
            state_nxt    = SHIFT;
            act_data_nxt = hold_data;
            act_dir_nxt  = hold_dir;
            bit_cnt_nxt  = 2'd0;
        end else if (last_bit) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 2'd0;
        end else if (state == SHIFT) begin
            bit_cnt_nxt = bit_cnt + 2'd1;
        end

        busy_nxt = (state_nxt == SHIFT);
        mode_nxt = busy_nxt ? act_dir_nxt : Mode;
        sr_nxt   = busy_nxt && act_dir_nxt && act_data_nxt[2'd3 - bit_cnt_nxt];
        sl_nxt   = busy_nxt && !act_dir_nxt && act_data_nxt[bit_cnt_nxt];
        done_nxt = busy_nxt && (bit_cnt_nxt == 2'd3);
    end

endmodule

// File: doc/shift_feeder.md
SHIFT_FEEDER -- requirements
Module: shift_feeder

Interface
REQ-001 Parameter WIDTH, default 4, bits per frame; SHALL equal the downstream 4-stage shift register depth; only 4 is required to be supported.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 CLR  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  upstream word valid.
REQ-005 in_dir  input  1  frame direction: 1 = shift right (downstream Mode=1), 0 = shift left.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 Mode  output  1  direction select to the downstream shift register.
REQ-009 ShiftRight  output  1  serial bit for right-shift frames.
REQ-010 ShiftLeft  output  1  serial bit for left-shift frames.
REQ-011 busy  output  1  a frame bit is being driven this cycle.
REQ-012 frame_done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-013 Storage SHALL be one holding entry (hold_data, hold_dir, hold_valid) plus one active shift entry (act_data, act_dir, 2-bit bit counter, state IDLE/SHIFT).
REQ-014 in_ready SHALL equal !hold_valid; a word is accepted at a rising edge where in_valid && in_ready.
REQ-015 When in_valid is high and in_ready is low, the word SHALL be ignored and not stored; the source holds it.
REQ-016 At an edge where hold_valid and (state==IDLE or the counter is on the last bit), hold SHALL move into active, hold_valid SHALL clear, and the state SHALL become SHIFT with counter 0, unless a new word is accepted at that same edge.
REQ-017 Simultaneous accept and hold-to-active transfer SHALL NOT occur, because in_ready is low while hold is valid.
REQ-018 Latency: a word accepted at edge E SHALL drive its first bit in the cycle after edge E+1 when idle, and its bits SHALL occupy cycles E+1..E+4.
REQ-019 Bit order, right frame: d[3], d[2], d[1], d[0] on ShiftRight, with Mode=1 and ShiftLeft=0.
REQ-020 Bit order, left frame: d[0], d[1], d[2], d[3] on ShiftLeft, with Mode=0 and ShiftRight=0.
REQ-021 After exactly 4 downstream clocks, both bit orders leave out1=d[0] and out4=d[3] in the downstream register.
REQ-022 Mode, ShiftRight, ShiftLeft, busy and frame_done SHALL be registered, with no combinational path from inputs.
REQ-023 frame_done SHALL be high only in the cycle carrying the last bit (counter==3).
REQ-024 After the last bit: if the next word is in hold, its first bit SHALL follow in the next cycle with no gap; otherwise the state SHALL return to IDLE.
REQ-025 In IDLE, ShiftRight=ShiftLeft=0, busy=0, frame_done=0, and Mode SHALL hold the last frame's direction, so an always-clocking downstream register shifts in zeros.
REQ-026 A direction change between consecutive frames SHALL take effect on the new frame's first bit cycle.

Reset
REQ-027 While CLR=0, all outputs and state SHALL be cleared asynchronously: Mode=0, ShiftRight=0, ShiftLeft=0, busy=0, frame_done=0, hold_valid=0, state IDLE, counter 0, in_ready=1 once CLR is released.
REQ-028 A reset mid-frame or with hold full SHALL discard both words, with no partial frame resuming after release.
REQ-029 The first acceptance SHALL be possible at the first rising edge with CLR=1.

Verification
REQ-030 Reset then idle 10 cycles -> Mode=0, ShiftRight=ShiftLeft=0, in_ready=1, busy=0.
REQ-031 Accept in_dir=1, in_data=4'b1011 -> ShiftRight=1,0,1,1 on 4 consecutive cycles, Mode=1, frame_done on the 4th cycle; downstream out4..out1=1,0,1,1.
REQ-032 Accept in_dir=0, in_data=4'b0110 -> ShiftLeft=0,1,1,0, Mode=0; downstream out1=0, out2=1, out3=1, out4=0.
REQ-033 Back-to-back words 4'hA right then 4'h5 left with in_valid held -> 8 contiguous busy cycles, Mode switches 1->0 at cycle 5, two frame_done pulses, in_ready low while hold is full.
REQ-034 Assert CLR=0 at bit 2 of a frame with hold full -> outputs 0 immediately; after release, no bits are emitted until a new accept.
REQ-035 in_valid with in_ready=0 and changing in_data -> the ignored words never appear on the serial outputs.
